// File: rtl/dcache_controller_if.sv
// Pipeline-side and memory-side signal bundle of the data cache controller.
// slave = cache controller, master = pipeline/memory driver.
interface dcache_controller_if #(
    parameter int LINE_BITS = 256
);
    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [31:0]          cpu_addr_i;
    logic [31:0]          cpu_data_i;
    logic [31:0]          cpu_data_o;
    logic                 cpu_stall_o;
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: hits answer combinationally with no stall;
// a miss stalls the pipeline through an optional writeback then a refill, each held until mem_ack_i.
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_BITS  = 22
) (
    input logic               clk_i,
    input logic               rst_i,
    dcache_controller_if.slave bus
);
    localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int WSEL_BITS = $clog2(LINE_BITS / 32);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WB_REQ = 2'd1;
    localparam logic [1:0] ST_RD_REQ = 2'd2;

    logic [1:0]           state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [TAG_BITS-1:0]  req_tag_q;
    logic [IDX_BITS-1:0]  req_idx_q;
    logic                 req_we_q;
    logic [31:0]          req_data_q;
    logic                 fill_done_q;

    logic [TAG_BITS-1:0]  addr_tag;
    logic [IDX_BITS-1:0]  addr_idx;
    logic [WSEL_BITS-1:0] addr_word;
    logic [WSEL_BITS+4:0] word_bit;
    logic [LINE_BITS-1:0] idx_line;
    logic                 hit;
    logic                 idle;
    logic                 miss_start;
    logic                 store_hit;
    logic                 fill_ack;

    assign addr_tag  = bus.cpu_addr_i[31 -: TAG_BITS];
    assign addr_idx  = bus.cpu_addr_i[OFF_BITS +: IDX_BITS];
    assign addr_word = bus.cpu_addr_i[2 +: WSEL_BITS];
    assign word_bit  = {addr_word, 5'b00000};
    assign idx_line  = data_q[addr_idx];

    assign hit        = bus.cpu_req_i & valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
    assign idle       = (state_q == ST_IDLE);
    assign miss_start = idle & bus.cpu_req_i & ~hit & ~rst_i;
    assign store_hit  = idle & hit & bus.cpu_we_i & ~rst_i;
    assign fill_ack   = (state_q == ST_RD_REQ) & bus.mem_ack_i & ~rst_i;

    always_comb begin
        bus.cpu_stall_o  = 1'b0;
        bus.cpu_data_o   = '0;
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_data_o   = '0;
        case (state_q)
            ST_IDLE: begin
                bus.cpu_stall_o = bus.cpu_req_i & ~hit;
                if (hit) begin
                    bus.cpu_data_o = idx_line[word_bit +: 32];
                end
            end
            ST_WB_REQ: begin
                bus.cpu_stall_o  = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = {tag_q[req_idx_q], req_idx_q, {OFF_BITS{1'b0}}};
                bus.mem_data_o   = data_q[req_idx_q];
            end
            ST_RD_REQ: begin
                bus.cpu_stall_o  = 1'b1;
                bus.mem_enable_o = 1'b1;
                bus.mem_addr_o   = {req_tag_q, req_idx_q, {OFF_BITS{1'b0}}};
            end
            default: begin
                bus.cpu_stall_o = 1'b1;
            end
        endcase
    end

    // Control state: only valid/dirty and the FSM are reset; tags and data are gated by valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (miss_start) begin
                        state_q <= (valid_q[addr_idx] & dirty_q[addr_idx]) ? ST_WB_REQ : ST_RD_REQ;
                    end else if (store_hit) begin
                        dirty_q[addr_idx] <= 1'b1;
                    end
                end
                ST_WB_REQ: begin
                    if (bus.mem_ack_i) begin
                        dirty_q[req_idx_q] <= 1'b0;
                        state_q            <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (bus.mem_ack_i) begin
                        valid_q[req_idx_q] <= 1'b1;
                        dirty_q[req_idx_q] <= 1'b0;
                        fill_done_q        <= 1'b1;
                        state_q            <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (miss_start) begin
            req_tag_q  <= addr_tag;
            req_idx_q  <= addr_idx;
            req_we_q   <= bus.cpu_we_i;
            req_data_q <= bus.cpu_data_i;
        end
        if (fill_ack) begin
            tag_q[req_idx_q]  <= req_tag_q;
            data_q[req_idx_q] <= bus.mem_data_i;
        end else if (store_hit) begin
            data_q[addr_idx][word_bit +: 32] <= bus.cpu_data_i;
        end
    end

    // The frozen pipeline must replay the missed request unchanged (or drop it) once the fill lands.
    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.cpu_req_i) begin
            assert (bus.cpu_addr_i[1:0] == 2'b00);
            if (fill_done_q) begin
                assert (bus.cpu_we_i == req_we_q && addr_tag == req_tag_q && addr_idx == req_idx_q
                        && (!req_we_q || bus.cpu_data_i == req_data_q));
            end
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed plus random accesses against a line-level cache/memory reference model.
module tb_dcache_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_controller_if #(.LINE_BITS(256)) bus ();

    dcache_controller #(.NUM_LINES(32), .LINE_BITS(256), .TAG_BITS(22)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    bit            m_valid [32];
    bit            m_dirty [32];
    logic [21:0]   m_tag   [32];
    logic [255:0]  m_data  [32];
    logic [255:0]  mem_m   [int unsigned];
    int            checks = 0;
    int            errors = 0;
    bit            drop_g = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic get_line(input int unsigned ln, output logic [255:0] line);
        if (!mem_m.exists(ln)) begin
            logic [255:0] v;
            for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
            mem_m[ln] = v;
        end
        line = mem_m[ln];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.mem_ack_i = 1'b0;
        for (int i = 0; i < 8; i++) bus.mem_data_i[i*32 +: 32] = $urandom;
    endtask

    task automatic handshake(input bit wr, input logic [31:0] addr, input logic [255:0] line, input int w);
        for (int k = 1; k <= w; k++) begin
            next_cycle();
            if (drop_g) bus.cpu_req_i = 1'b0;
            if (k == w) begin
                bus.mem_ack_i = 1'b1;
                if (!wr) bus.mem_data_i = line;
            end
            #1;
            check("hs_enable", bus.mem_enable_o, 1'b1);
            check("hs_write", bus.mem_write_o, wr);
            check("hs_addr", bus.mem_addr_o, addr);
            if (wr) check("wb_data", bus.mem_data_o, line);
            check("hs_stall", bus.cpu_stall_o, 1'b1);
            check("hs_cpu_data", bus.cpu_data_o, 32'd0);
        end
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] data,
                          input int w_wb, input int w_rd, input bit drop);
        logic [4:0]   idx;
        logic [21:0]  tg;
        int           wd;
        bit           hit;
        logic [255:0] line;
        idx = addr[9:5];
        tg  = addr[31:10];
        wd  = int'(addr[4:2]);
        next_cycle();
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = we;
        bus.cpu_addr_i = addr;
        bus.cpu_data_i = data;
        #1;
        hit = m_valid[idx] && (m_tag[idx] == tg);
        check("stall_c0", bus.cpu_stall_o, !hit);
        check("enable_c0", bus.mem_enable_o, 1'b0);
        if (hit) begin
            if (!we) check("load_hit", bus.cpu_data_o, m_data[idx][wd*32 +: 32]);
            else begin
                m_data[idx][wd*32 +: 32] = data;
                m_dirty[idx] = 1'b1;
            end
            return;
        end
        check("miss_data", bus.cpu_data_o, 32'd0);
        drop_g = drop;
        if (m_valid[idx] && m_dirty[idx]) begin
            handshake(1'b1, {m_tag[idx], idx, 5'b0}, m_data[idx], w_wb);
            mem_m[{m_tag[idx], idx}] = m_data[idx];
            m_dirty[idx] = 1'b0;
        end
        get_line({tg, idx}, line);
        handshake(1'b0, {tg, idx, 5'b0}, line, w_rd);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = line;
        m_dirty[idx] = 1'b0;
        next_cycle();
        #1;
        check("ret_enable", bus.mem_enable_o, 1'b0);
        check("ret_stall", bus.cpu_stall_o, 1'b0);
        if (!drop) begin
            if (!we) check("ret_load", bus.cpu_data_o, line[wd*32 +: 32]);
            else begin
                m_data[idx][wd*32 +: 32] = data;
                m_dirty[idx] = 1'b1;
            end
        end
        drop_g = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst            = 1'b1;
        bus.cpu_req_i  = 1'b0;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = '0;
        bus.cpu_data_i = '0;
        bus.mem_data_i = '0;
        bus.mem_ack_i  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_stall", bus.cpu_stall_o, 1'b0);
        check("rst_enable", bus.mem_enable_o, 1'b0);
        check("rst_write", bus.mem_write_o, 1'b0);
        check("rst_cpu_data", bus.cpu_data_o, 32'd0);
        check("rst_mem_addr", bus.mem_addr_o, 32'd0);

        // clean fill, store hit, load hit, dirty conflict
        access(1'b0, 32'h0000_0040, 32'd0, 1, 3, 1'b0);
        access(1'b1, 32'h0000_0044, 32'hDEADBEEF, 1, 1, 1'b0);
        access(1'b0, 32'h0000_0044, 32'd0, 1, 1, 1'b0);
        access(1'b0, 32'h0000_0440, 32'd0, 2, 2, 1'b0);
        // store miss with write-allocate, then a conflicting miss writes it back
        access(1'b1, 32'h0000_0804, 32'h1234_5678, 1, 2, 1'b0);
        access(1'b0, 32'h0000_0804, 32'd0, 1, 1, 1'b0);
        access(1'b0, 32'h0000_0004, 32'd0, 2, 1, 1'b0);
        // request withdrawn mid-miss: fill completes, store not applied
        access(1'b1, 32'h0000_00C8, 32'hCAFE_F00D, 1, 2, 1'b1);
        access(1'b0, 32'h0000_00C8, 32'd0, 1, 1, 1'b0);

        // reset during a refill, then a late ack
        access(1'b0, 32'h0000_0060, 32'd0, 1, 2, 1'b0);
        next_cycle();
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_0100;
        #1;
        check("rrst_stall_c0", bus.cpu_stall_o, 1'b1);
        next_cycle();
        #1;
        check("rrst_enable", bus.mem_enable_o, 1'b1);
        check("rrst_addr", bus.mem_addr_o, 32'h0000_0100);
        next_cycle();
        rst = 1'b1;
        bus.cpu_req_i = 1'b0;
        next_cycle();
        rst = 1'b0;
        bus.mem_ack_i = 1'b1;
        #1;
        check("post_rst_enable", bus.mem_enable_o, 1'b0);
        check("post_rst_write", bus.mem_write_o, 1'b0);
        check("post_rst_stall", bus.cpu_stall_o, 1'b0);
        next_cycle();
        #1;
        check("late_ack_enable", bus.mem_enable_o, 1'b0);
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        access(1'b0, 32'h0000_0060, 32'd0, 1, 1, 1'b0);

        // idle with random address and spurious ack
        next_cycle();
        bus.cpu_req_i  = 1'b0;
        bus.cpu_addr_i = $urandom;
        bus.mem_ack_i  = 1'b1;
        #1;
        check("idle_stall", bus.cpu_stall_o, 1'b0);
        check("idle_enable", bus.mem_enable_o, 1'b0);
        next_cycle();
        #1;
        check("idle_enable_next", bus.mem_enable_o, 1'b0);
        check("idle_stall_next", bus.cpu_stall_o, 1'b0);

        // random traffic over a few conflicting tags and indices
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                next_cycle();
                bus.cpu_req_i = 1'b0;
                #1;
                check("rand_idle_stall", bus.cpu_stall_o, 1'b0);
            end
            a = '0;
            a[31:10] = 22'($urandom_range(0, 3));
            a[9:5]   = 5'($urandom_range(0, 3));
            a[4:2]   = 3'($urandom_range(0, 7));
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 3),
                   $urandom_range(1, 3), $urandom_range(0, 9) == 0);
        end

        next_cycle();
        bus.cpu_req_i = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and a line-wide data memory.
- Generates `cpu_stall_o`, which freezes all pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) through their `cpu_stall_i` inputs while a miss is serviced.
- Issues line writebacks and refills on a level-hold/ack memory handshake.

Parameters:
- NUM_LINES, 32, number of cache lines (index width log2 = 5)
- LINE_BITS, 256, line width in bits (32 bytes, 8 words)
- TAG_BITS, 22, tag width (32 − 5 index − 5 offset)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- cpu_req_i  in  1  MEM stage issues a load or store this cycle
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address; word-aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data (combinational)
- cpu_stall_o  out  1  pipeline stall request (combinational)
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = writeback, 0 = refill read
- mem_addr_o  out  32  line-aligned memory address
- mem_data_o  out  256  writeback line data
- mem_data_i  in  256  refill line data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle pulse: request complete

Behaviour:
- Address split:
  - tag = addr[31:10]
  - index = addr[9:5]
  - word = addr[4:2]
  - addr[1:0] ignored
- Storage per line: valid, dirty, tag[21:0], data[255:0].
- hit = cpu_req_i & valid[index] & (tag[index] == tag).
- States: IDLE, WB_REQ, RD_REQ.
- IDLE:
  - cpu_stall_o = cpu_req_i & ~hit.
  - Load hit: cpu_data_o = selected word, same cycle, no stall.
  - Store hit: selected word written and dirty set at the next edge.
  - When not a hit, cpu_data_o = 0.
  - cpu_req_i low: no stall, no state change.
- Miss in IDLE:
  - Latch tag, index, we, data into internal request registers.
  - Next state is WB_REQ if the victim is valid & dirty, else RD_REQ.
- WB_REQ:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim_tag, index, 5'b0}; mem_data_o = victim line.
  - Held stable until mem_ack_i. On ack: clear dirty, go to RD_REQ.
- RD_REQ:
  - mem_enable_o = 1, mem_write_o = 0.
  - mem_addr_o = {req_tag, index, 5'b0}.
  - On ack: line = mem_data_i, tag = req_tag, valid = 1, dirty = 0, go to IDLE.
- cpu_stall_o = 1 in every non-IDLE state.
- Returning to IDLE:
  - The stalled pipeline still presents the same request, which now hits.
  - Stall drops that cycle; a load returns data, a store performs the write-allocate update.
- Latency:
  - Clean miss detected in cycle 0, ack in cycle t (t ≥ 1): mem_enable_o high cycles 1..t, stall high cycles 0..t, hit completes in cycle t+1.
  - Dirty miss adds the writeback handshake in front of the refill.
- mem_ack_i in IDLE is ignored.
- cpu_req_i dropping mid-miss: the fill still completes (latched request); stall stays asserted until IDLE.
- mem_enable_o and mem_write_o are 0 in IDLE. mem_addr_o and mem_data_o are don't-care in IDLE but driven 0.
- Reset (any state, including mid-transaction):
  - All valid and dirty bits cleared, state = IDLE.
  - mem_enable_o = 0, mem_write_o = 0, cpu_stall_o = 0 from the cycle after reset.
  - An in-flight transaction is abandoned; dirty data is discarded.
  - A late mem_ack_i after reset is ignored.
- Tag and data arrays are not cleared by reset; valid gates all hits.

Test Plan:
- Post-reset load 0x0000_0040, ack 3 cycles after mem_enable_o → stall high 4 cycles, refill read at 0x0000_0040, then cpu_data_o = word 0 of mem_data_i; no writeback issued.
- Store 0xDEADBEEF to 0x0000_0044 after that fill → no stall, next load 0x0000_0044 returns 0xDEADBEEF with zero stall.
- Load 0x0000_0440 (same index, new tag) with line dirty → writeback at 0x0000_0040 carrying 0xDEADBEEF in word 1, then refill at 0x0000_0440; stall covers both handshakes.
- Store miss to 0x0000_0804 → refill, then the word written and line dirty; later conflicting miss triggers writeback.
- Assert rst_i during RD_REQ before ack, then pulse mem_ack_i → mem_enable_o low next cycle, stall low, ack ignored, earlier-filled line now misses.
- cpu_req_i low with random address and a spurious mem_ack_i → cpu_stall_o = 0, state stays IDLE, no mem_enable_o.
